// File: rtl/rps_match_master.sv
// Rock-paper-scissors match sequencer: pairs a human move with an LFSR
// opponent, hands the round to an external judge and keeps the score.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   go                player button level; a rising edge requests a round
//   clear             synchronous score clear / new match
//   p1_move_in        human move (00 stone, 01 paper, 10 scissors)
//   winner_in         judge verdict (00 tie, 01 p1, 10 p2, 11 invalid)
//   winner_valid      judge strobe qualifying winner_in
//   p1_move, p2_move  moves presented to the judge
//   start             one-cycle round-start strobe to the judge
//   p1_score, p2_score, ties  saturating round tallies
//   match_done        match finished; match_winner 01 p1, 10 p2
//   busy              round in flight; err sticky fault flag

module rps_match_master #(
    parameter int WINS_NEEDED = 3,
    parameter int TIMEOUT     = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       clear,
    input  logic [1:0] p1_move_in,
    input  logic [1:0] winner_in,
    input  logic       winner_valid,
    output logic [1:0] p1_move,
    output logic [1:0] p2_move,
    output logic       start,
    output logic [2:0] p1_score,
    output logic [2:0] p2_score,
    output logic [2:0] ties,
    output logic       match_done,
    output logic [1:0] match_winner,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_TALLY,
        S_DONE
    } state_t;

    localparam logic [2:0] WINS = 3'(WINS_NEEDED);
    localparam logic [3:0] TMO  = 4'(TIMEOUT);
    localparam logic [2:0] SAT  = 3'd7;

    state_t     state;
    state_t     state_nxt;

    logic [7:0] lfsr;
    logic       lfsr_fb;
    logic [1:0] p2_map;

    logic       go_prev;
    logic       go_edge;

    logic [3:0] tmo_cnt;
    logic [3:0] tmo_inc;
    logic       tmo_hit;

    logic [1:0] verdict;

    logic [2:0] p1_nxt;
    logic [2:0] p2_nxt;
    logic [2:0] ties_nxt;
    logic       tally_err;
    logic       reach;

    // Opponent source, free-running from reset release
    // (taps 8,6,5,4 -> bits 7,5,4,3).
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end

    // Fold the illegal code 11 back onto stone/paper.
    assign p2_map = (lfsr[1:0] == 2'b11) ? {1'b0, lfsr[2]}
                                         : lfsr[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            go_prev <= 1'b0;
        end else begin
            go_prev <= go;
        end
    end

    assign go_edge = go & ~go_prev;

    assign tmo_inc = tmo_cnt + 4'd1;
    assign tmo_hit = (tmo_inc == TMO);

    // Score update applied on the TALLY edge.
    always_comb begin
        p1_nxt    = p1_score;
        p2_nxt    = p2_score;
        ties_nxt  = ties;
        tally_err = 1'b0;
        case (verdict)
            2'b01: begin
                if (p1_score != SAT) begin
                    p1_nxt = p1_score + 3'd1;
                end
            end
            2'b10: begin
                if (p2_score != SAT) begin
                    p2_nxt = p2_score + 3'd1;
                end
            end
            2'b00: begin
                if (ties != SAT) begin
                    ties_nxt = ties + 3'd1;
                end
            end
            default: begin
                tally_err = 1'b1;
            end
        endcase
    end

    assign reach = (p1_nxt == WINS) || (p2_nxt == WINS);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; clear overrides everything.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go_edge) begin
                        state_nxt = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    // A verdict on the timeout cycle still counts.
                    if (winner_valid) begin
                        state_nxt = S_TALLY;
                    end else if (tmo_hit) begin
                        state_nxt = S_IDLE;
                    end
                end
                S_TALLY: begin
                    state_nxt = reach ? S_DONE : S_IDLE;
                end
                S_DONE: begin
                    state_nxt = S_DONE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_move      <= 2'b00;
            p2_move      <= 2'b00;
            verdict      <= 2'b00;
            tmo_cnt      <= 4'd0;
            p1_score     <= 3'd0;
            p2_score     <= 3'd0;
            ties         <= 3'd0;
            match_winner <= 2'b00;
            err          <= 1'b0;
        end else if (clear) begin
            // Moves are left alone so the judge bus stays stable.
            tmo_cnt      <= 4'd0;
            p1_score     <= 3'd0;
            p2_score     <= 3'd0;
            ties         <= 3'd0;
            match_winner <= 2'b00;
            err          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go_edge) begin
                        p1_move <= p1_move_in;
                        p2_move <= p2_map;
                    end
                end
                S_ISSUE: begin
                    tmo_cnt <= 4'd0;
                end
                S_WAIT: begin
                    if (winner_valid) begin
                        verdict <= winner_in;
                    end else begin
                        tmo_cnt <= tmo_inc;
                        if (tmo_hit) begin
                            err <= 1'b1;
                        end
                    end
                end
                S_TALLY: begin
                    p1_score <= p1_nxt;
                    p2_score <= p2_nxt;
                    ties     <= ties_nxt;
                    if (tally_err) begin
                        err <= 1'b1;
                    end
                    if (reach) begin
                        match_winner <= (p1_nxt == WINS) ? 2'b01
                                                         : 2'b10;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Moore outputs decoded from the state.
    always_comb begin
        start      = 1'b0;
        busy       = 1'b0;
        match_done = 1'b0;
        unique case (1'b1)
            (state == S_ISSUE): begin
                start = 1'b1;
                busy  = 1'b1;
            end
            (state == S_WAIT),
            (state == S_TALLY): begin
                busy = 1'b1;
            end
            (state == S_DONE): begin
                match_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
